// File: rtl/mmio_bus_if.sv
// Core-side load/store handshake of the MMIO interconnect.
// The core drives requests (master); the interconnect answers (slave).
interface mmio_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              m_fault;
    logic [1:0]        m_fault_code;

    modport master (
        output m_valid, m_we, m_size, m_addr, m_wdata,
        input  m_ready, m_rvalid, m_rdata,
        input  m_fault, m_fault_code
    );

    modport slave (
        input  m_valid, m_we, m_size, m_addr, m_wdata,
        output m_ready, m_rvalid, m_rdata,
        output m_fault, m_fault_code
    );
endinterface

// File: rtl/mmio_bus.sv
// MMIO interconnect: decodes core accesses onto N slave windows,
// one outstanding transaction, registered response, fault reporting.
module mmio_bus #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK = '0,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       resetn,
    mmio_bus_if.slave                  m,
    output logic [N_SLAVES-1:0]        s_sel,
    output logic                       s_valid,
    output logic                       s_we,
    output logic [1:0]                 s_size,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES-1:0]        s_ready,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]    cnt;
    logic [N_SLAVES-1:0] sel_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                fault_q;
    logic [1:0]          code_q;

    logic                bad_align;
    logic                hit;
    logic [N_SLAVES-1:0] hit_sel;
    logic [ADDR_W-1:0]   hit_off;
    logic                rdy;
    logic                tmo;
    logic [DATA_W-1:0]   sel_rdata;

    // Alignment check: size 3 is never legal
    always_comb begin
        unique case (m.m_size)
            2'd0:    bad_align = 1'b0;
            2'd1:    bad_align = m.m_addr[0];
            2'd2:    bad_align = |m.m_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    // Window decode; descending scan so the lowest index wins overlaps
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_off = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m.m_addr & MASK[i*ADDR_W +: ADDR_W])
                == BASE[i*ADDR_W +: ADDR_W]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit_off    = m.m_addr & ~MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Selected slave's ready and read data; other slaves are ignored
    always_comb begin
        rdy       = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; ready beats a same-cycle timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (m.m_valid) begin
                    state_nx = (bad_align || !hit) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (rdy || tmo) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM-derived handshake outputs
    always_comb begin
        m.m_ready  = (state == IDLE);
        m.m_rvalid = (state == RESP);
        s_valid    = (state == ACCESS);
    end

    assign s_sel          = sel_q;
    assign m.m_rdata      = rdata_q;
    assign m.m_fault      = fault_q;
    assign m.m_fault_code = code_q;

    // Request latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            sel_q   <= '0;
            s_we    <= 1'b0;
            s_size  <= 2'd0;
            s_addr  <= '0;
            s_wdata <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m.m_valid) begin
                        s_we    <= m.m_we;
                        s_size  <= m.m_size;
                        s_wdata <= m.m_wdata;
                        cnt     <= '0;
                        if (bad_align) begin
                            rdata_q <= '0;
                            fault_q <= 1'b1;
                            code_q  <= 2'b10;
                        end else if (!hit) begin
                            rdata_q <= '0;
                            fault_q <= 1'b1;
                            code_q  <= 2'b01;
                        end else begin
                            sel_q   <= hit_sel;
                            s_addr  <= hit_off;
                        end
                    end
                end
                ACCESS: begin
                    if (rdy) begin
                        rdata_q <= s_we ? '0 : sel_rdata;
                        fault_q <= 1'b0;
                        code_q  <= 2'b00;
                        sel_q   <= '0;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        fault_q <= 1'b1;
                        code_q  <= 2'b11;
                        sel_q   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
